// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive paths.
//   PAR_NONE / PAR_ODD / PAR_EVEN : parity mode encodings (PARITY_MODE values)
//   tx_state_t                    : transmit serialiser state encoding
//   baud_div()                    : clock cycles per bit, rounded to nearest
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Cycles per bit, rounded to the nearest integer rather than truncated.
    function automatic int baud_div(input int clk, input int baud);
        return (clk + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter shared by the transmit serialiser and the receive sampler.
// Counts 0 .. DIV-1 and wraps; tick is high while the count sits on DIV-1.
//   clk      : clock
//   rst      : synchronous active-high reset (count -> 0)
//   clr      : synchronous clear (count -> 0), highest priority after reset
//   load     : load load_val (the receiver uses this to align to mid-bit)
//   load_val : value loaded when load is high
//   tick     : bit-end indication, count == DIV-1
module uart_baud_cnt #(
    parameter int DIV   = 434,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // NOTE: every signal written in always_comb is given a value on all paths
    // (here the first assignment), otherwise a latch would be inferred.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (tick) begin
            cnt_d = '0;
        end
    end

    // NOTE: flops are written with non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_driver.sv
// UART transmit serialiser: start bit, 8 data bits LSB first, optional
// parity, 1 or 2 stop bits. All outputs are registered.
//   clk_sys              : system clock
//   rst                  : synchronous active-high reset
//   driver_tx_data       : byte to send, sampled only on the accept cycle
//   driver_tx_data_valid : one-cycle send request
//   tx_busy              : high while a frame is in progress
//   uart_txd             : serial line, idle high
//   tx_done              : one-cycle pulse after the last stop bit
//   tx_overrun           : one-cycle pulse, a request arrived while busy
module uart_tx_driver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int U_DLY       = 1
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic [7:0] driver_tx_data,
    input  logic       driver_tx_data_valid,
    output logic       tx_busy,
    output logic       uart_txd,
    output logic       tx_done,
    output logic       tx_overrun
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W    = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);

    if (BAUD_DIV < 2) begin : g_chk_div
        $error("uart_tx_driver: BAUD_DIV must be at least 2");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_chk_par
        $error("uart_tx_driver: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("uart_tx_driver: STOP_BITS must be 1 or 2");
    end
    // U_DLY matches the interface of the surrounding UART blocks; these
    // registers carry no assignment delay, so it is only range-checked.
    if (U_DLY < 0) begin : g_chk_dly
        $error("uart_tx_driver: U_DLY must not be negative");
    end

    tx_state_t  state_q,    state_d;
    logic [7:0] shift_q,    shift_d;
    logic [2:0] bit_idx_q,  bit_idx_d;
    logic       parity_q,   parity_d;    // line value of the parity bit
    logic       stop_cnt_q, stop_cnt_d;  // second stop bit in progress
    logic       txd_q,      txd_d;
    logic       done_q,     done_d;
    logic       overrun_q,  overrun_d;

    logic cnt_clr;
    logic cnt_load;
    logic cnt_tick;

    uart_baud_cnt #(
        .DIV   (BAUD_DIV),
        .CNT_W (CNT_W)
    ) u_baud_cnt (
        .clk      (clk_sys),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val ('0),
        .tick     (cnt_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        parity_d   = parity_q;
        stop_cnt_d = stop_cnt_q;
        done_d     = 1'b0;
        cnt_clr    = 1'b0;
        cnt_load   = 1'b0;
        // Requests are only accepted in IDLE; anything else is dropped and flagged.
        overrun_d  = driver_tx_data_valid && (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (driver_tx_data_valid) begin
                    shift_d   = driver_tx_data;
                    bit_idx_d = '0;
                    parity_d  = (PARITY_MODE == int'(PAR_ODD)) ? ~^driver_tx_data
                                                                :  ^driver_tx_data;
                    cnt_clr   = 1'b0;
                    cnt_load  = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                if (cnt_tick) state_d = DATA;
            end
            DATA: begin
                if (cnt_tick) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        stop_cnt_d = 1'b0;
                        state_d    = (PARITY_MODE != int'(PAR_NONE)) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (cnt_tick) begin
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (cnt_tick) begin
                    if (STOP_BITS == 2 && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the next state so uart_txd changes on the same
        // edge as the state register and comes straight from a flop.
        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = parity_d;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            parity_q   <= 1'b0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            parity_q   <= parity_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign tx_busy    = (state_q != IDLE);
    assign uart_txd   = txd_q;
    assign tx_done    = done_q;
    assign tx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_driver.sv
// Bench for uart_tx_driver: four instances with different line settings,
// each driven by random bytes and compared cycle by cycle against a frame
// built from the protocol rules (bit list expanded to cycles).
module tb_uart_tx_driver;

    localparam int NI = 4;

    logic       clk_sys = 1'b0;
    logic       rst     = 1'b1;
    logic [7:0] data  [NI];
    logic       valid [NI];
    logic       busy  [NI];
    logic       txd   [NI];
    logic       done  [NI];
    logic       ovr   [NI];

    // Line settings of each instance as the reference model sees them.
    int div_m  [NI] = '{434, 4, 4, 4};
    int par_m  [NI] = '{0, 2, 1, 2};   // 0 none, 1 odd, 2 even
    int stop_m [NI] = '{1, 1, 1, 2};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_sys = ~clk_sys;

    uart_tx_driver #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
        .clk_sys(clk_sys), .rst(rst), .driver_tx_data(data[0]), .driver_tx_data_valid(valid[0]),
        .tx_busy(busy[0]), .uart_txd(txd[0]), .tx_done(done[0]), .tx_overrun(ovr[0]));
    uart_tx_driver #(.CLK_FREQ(4), .BAUD_RATE(1), .PARITY_MODE(2), .STOP_BITS(1)) u_dut1 (
        .clk_sys(clk_sys), .rst(rst), .driver_tx_data(data[1]), .driver_tx_data_valid(valid[1]),
        .tx_busy(busy[1]), .uart_txd(txd[1]), .tx_done(done[1]), .tx_overrun(ovr[1]));
    uart_tx_driver #(.CLK_FREQ(4), .BAUD_RATE(1), .PARITY_MODE(1), .STOP_BITS(1)) u_dut2 (
        .clk_sys(clk_sys), .rst(rst), .driver_tx_data(data[2]), .driver_tx_data_valid(valid[2]),
        .tx_busy(busy[2]), .uart_txd(txd[2]), .tx_done(done[2]), .tx_overrun(ovr[2]));
    uart_tx_driver #(.CLK_FREQ(4), .BAUD_RATE(1), .PARITY_MODE(2), .STOP_BITS(2)) u_dut3 (
        .clk_sys(clk_sys), .rst(rst), .driver_tx_data(data[3]), .driver_tx_data_valid(valid[3]),
        .tx_busy(busy[3]), .uart_txd(txd[3]), .tx_done(done[3]), .tx_overrun(ovr[3]));

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Sends byte b on instance i and checks the whole frame. Called and
    // returns on a falling edge. ovr_sel: -1 none, -2 random position,
    // otherwise the frame cycle at which a stray 0xFF request is injected.
    task automatic send_frame(input int i, input logic [7:0] b, input int ovr_sel);
        logic exp_line[$];
        logic bits[$];
        int   n_frame;
        int   ovr_at;
        int   first_bad = -1;
        int   busy_cnt  = 0;

        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(b[k]);
        if (par_m[i] == 2) bits.push_back(^b);
        if (par_m[i] == 1) bits.push_back(~^b);
        for (int k = 0; k < stop_m[i]; k++) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int c = 0; c < div_m[i]; c++) exp_line.push_back(bits[k]);
        end
        n_frame = exp_line.size();
        check($sformatf("frame_len_%0d", i), n_frame, div_m[i] * (9 + (par_m[i] != 0 ? 1 : 0) + stop_m[i]));
        ovr_at = (ovr_sel == -2) ? $urandom_range(0, n_frame - 3) : ovr_sel;

        data[i]  = b;
        valid[i] = 1'b1;
        @(negedge clk_sys);
        valid[i] = 1'b0;
        data[i]  = 8'($urandom);   // later data changes must not reach the line

        for (int n = 0; n < n_frame; n++) begin
            if (n == 0) check($sformatf("busy_rise_%0d", i), int'(busy[i]), 1);
            if (busy[i] === 1'b1) busy_cnt++;
            if (first_bad < 0 && (txd[i] !== exp_line[n] || busy[i] !== 1'b1 || done[i] !== 1'b0))
                first_bad = n;
            if (ovr_at >= 0 && n == ovr_at + 1) begin
                check($sformatf("overrun_pulse_%0d", i), int'(ovr[i]), 1);
                valid[i] = 1'b0;
            end else if (first_bad < 0 && ovr[i] !== 1'b0) begin
                first_bad = n;
            end
            if (n == ovr_at) begin
                valid[i] = 1'b1;
                data[i]  = 8'hFF;
            end
            @(negedge clk_sys);
        end

        check($sformatf("frame_line_%0d_byte_%02h", i, b), first_bad, -1);
        check($sformatf("busy_len_%0d", i), busy_cnt, n_frame);
        check($sformatf("busy_fall_%0d", i), int'(busy[i]), 0);
        check($sformatf("done_pulse_%0d", i), int'(done[i]), 1);
        @(negedge clk_sys);
        check($sformatf("done_single_%0d", i), int'(done[i]), 0);
        check($sformatf("no_extra_frame_%0d", i), int'(busy[i]), 0);
    endtask

    // Starts a frame on instance i and resets it 20 cycles in.
    task automatic reset_abort(input int i, input logic [7:0] b);
        int done_seen = 0;
        int busy_seen = 0;
        data[i]  = b;
        valid[i] = 1'b1;
        @(negedge clk_sys);
        valid[i] = 1'b0;
        repeat (19) @(negedge clk_sys);
        rst = 1'b1;
        @(negedge clk_sys);
        check("rst_abort_txd",  int'(txd[i]),  1);
        check("rst_abort_busy", int'(busy[i]), 0);
        check("rst_abort_done", int'(done[i]), 0);
        rst = 1'b0;
        repeat (50) begin
            @(negedge clk_sys);
            if (done[i] !== 1'b0) done_seen++;
            if (busy[i] !== 1'b0) busy_seen++;
        end
        check("rst_abort_no_done", done_seen, 0);
        check("rst_abort_idle",    busy_seen, 0);
    endtask

    initial begin
        logic [7:0] fifo[$];
        int idle_cnt;
        int guard;

        for (int i = 0; i < NI; i++) begin
            valid[i] = 1'b0;
            data[i]  = 8'h00;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk_sys);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_txd_%0d",  i), int'(txd[i]),  1);
            check($sformatf("rst_busy_%0d", i), int'(busy[i]), 0);
            check($sformatf("rst_done_%0d", i), int'(done[i]), 0);
            check($sformatf("rst_ovr_%0d",  i), int'(ovr[i]),  0);
        end
        rst = 1'b0;
        @(negedge clk_sys);

        // Directed frames from the line settings of each instance.
        send_frame(0, 8'h55, -1);
        send_frame(0, 8'($urandom), -1);
        send_frame(1, 8'h80, -1);
        send_frame(2, 8'h80, -1);
        send_frame(3, 8'h80, -1);
        send_frame(1, 8'h3C, 10);

        reset_abort(1, 8'hA5);
        send_frame(1, 8'hC3, -1);

        // Random bytes, random gaps (including back-to-back), occasional stray requests.
        for (int i = 1; i < NI; i++) begin
            for (int f = 0; f < 12; f++) begin
                repeat ($urandom_range(0, 4)) @(negedge clk_sys);
                send_frame(i, 8'($urandom), ($urandom_range(0, 3) == 0) ? -2 : -1);
            end
        end

        // Upstream control: next FIFO read only after 3 idle cycles.
        fifo = '{8'h01, 8'h02, 8'h03};
        while (fifo.size() > 0) begin
            idle_cnt = 0;
            guard    = 0;
            while (idle_cnt < 3 && guard < 200) begin
                @(negedge clk_sys);
                idle_cnt = (busy[3] === 1'b0) ? idle_cnt + 1 : 0;
                guard++;
            end
            check("upstream_idle_wait", idle_cnt, 3);
            send_frame(3, fifo.pop_front(), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
